// File: rtl/psdi_dsp_pkg.sv
// Shared types and helpers for the PSDI audio DSP rate-degrade path.
package psdi_dsp_pkg;

    typedef enum logic [1:0] {
        MODE_BYP    = 2'b00,
        MODE_HOLD   = 2'b01,
        MODE_HOLDQ  = 2'b10,
        MODE_INTERP = 2'b11
    } mode_t;

    localparam int KMAX_DEFAULT = 4;

    // Zero or anything wider than the sample means full width (no requantization).
    function automatic logic [4:0] clamp_nq(input logic [4:0] nquant, input int w);
        if (nquant == 5'd0 || int'(nquant) > w) return 5'(w);
        return nquant;
    endfunction

endpackage

// File: rtl/psdi_requant.sv
// Round-half-up requantizer: keeps the top nq bits of a signed sample,
// saturating on positive overflow.
module psdi_requant #(
    parameter int W = 18
) (
    input  logic [W-1:0] datain,
    input  logic [4:0]   nq,
    output logic [W-1:0] dataout
);
    localparam logic [W:0]   ONE     = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};

    logic [4:0]   drop;
    logic [W:0]   sum;
    logic [W-1:0] keep;

    always_comb begin
        drop = 5'(W) - nq;
        keep = {W{1'b1}} << drop;
        sum  = {datain[W-1], datain} + ((drop == 5'd0) ? '0 : (ONE << (drop - 5'd1)));
        // Only a positive sample can overflow, since the rounding term is positive.
        if (!sum[W] && sum[W-1]) dataout = POS_MAX & keep;
        else                     dataout = sum[W-1:0] & keep;
    end

endmodule

// File: rtl/psdi_rate_degrade.sv
// Multichannel decimate / requantize / reconstruct stage. Input capture,
// then phase and A/B update, then the output register.
module psdi_rate_degrade
    import psdi_dsp_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int W    = 18,
    parameter int KMAX = KMAX_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_en,
    input  logic [1:0]       mode,
    input  logic [2:0]       nfreq_log2,
    input  logic [4:0]       nquant,
    input  logic [NCH*W-1:0] datain,
    output logic [NCH*W-1:0] dataout,
    output logic             endataout
);
    localparam logic [KMAX:0] SPAN_ONE = {{KMAX{1'b0}}, 1'b1};

    mode_t           cfg_mode_reg, s1_mode_reg;
    logic [2:0]      cfg_k_reg, s1_k_reg;
    logic [4:0]      cfg_nq_reg;
    logic [KMAX-1:0] phase_reg, s1_phase_reg, phase_last;
    logic            en_reg, s1_valid_reg, s1_capture_reg, endataout_reg;
    logic            capture, boundary, requant_on, emit;
    logic [2:0]      k_port;
    logic [4:0]      nq_eff;
    logic [KMAX:0]   span;

    always_comb begin
        span       = SPAN_ONE << cfg_k_reg;
        phase_last = KMAX'(span - SPAN_ONE);
        capture    = en_reg && (phase_reg == '0);
        boundary   = en_reg && (phase_reg == phase_last);
        requant_on = (cfg_mode_reg == MODE_HOLDQ) || (cfg_mode_reg == MODE_INTERP);
        nq_eff     = requant_on ? cfg_nq_reg : 5'(W);
        k_port     = (int'(nfreq_log2) > KMAX) ? 3'(KMAX) : nfreq_log2;
        emit       = s1_valid_reg && (s1_capture_reg || (s1_mode_reg == MODE_BYP)
                                      || (s1_mode_reg == MODE_INTERP));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cfg_mode_reg   <= mode_t'(mode);
            cfg_k_reg      <= k_port;
            cfg_nq_reg     <= clamp_nq(nquant, W);
            phase_reg      <= '0;
            en_reg         <= 1'b0;
            s1_valid_reg   <= 1'b0;
            s1_capture_reg <= 1'b0;
            s1_mode_reg    <= MODE_BYP;
            s1_k_reg       <= '0;
            s1_phase_reg   <= '0;
            endataout_reg  <= 1'b0;
        end else begin
            en_reg        <= data_en;
            s1_valid_reg  <= en_reg;
            endataout_reg <= emit;
            if (en_reg) begin
                s1_capture_reg <= capture;
                s1_mode_reg    <= cfg_mode_reg;
                s1_k_reg       <= cfg_k_reg;
                s1_phase_reg   <= phase_reg;
                phase_reg      <= boundary ? '0 : phase_reg + 1'b1;
            end
            // New settings apply from the phase-0 sample after the boundary.
            if (boundary) begin
                cfg_mode_reg <= mode_t'(mode);
                cfg_k_reg    <= k_port;
                cfg_nq_reg   <= clamp_nq(nquant, W);
            end
        end
    end

    assign endataout = endataout_reg;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [W-1:0]           din_reg, byp_reg, a_reg, b_reg, dout_reg, rq, interp;
        logic signed [W+KMAX:0] diff_ext, phase_ext, prod;

        psdi_requant #(.W(W)) u_requant (
            .datain (din_reg),
            .nq     (nq_eff),
            .dataout(rq)
        );

        // Result lies between A and B, so truncating to W bits is exact.
        always_comb begin
            diff_ext  = $signed({{(KMAX+1){b_reg[W-1]}}, b_reg})
                      - $signed({{(KMAX+1){a_reg[W-1]}}, a_reg});
            phase_ext = $signed({{(W+1){1'b0}}, s1_phase_reg});
            prod      = diff_ext * phase_ext;
            interp    = a_reg + W'(prod >>> s1_k_reg);
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                din_reg  <= '0;
                byp_reg  <= '0;
                a_reg    <= '0;
                b_reg    <= '0;
                dout_reg <= '0;
            end else begin
                if (data_en) din_reg <= datain[gi*W +: W];
                if (en_reg) begin
                    byp_reg <= din_reg;
                    if (capture && cfg_mode_reg != MODE_BYP) begin
                        if (cfg_mode_reg == MODE_INTERP) a_reg <= b_reg;
                        b_reg <= rq;
                    end
                end
                if (emit) begin
                    case (s1_mode_reg)
                        MODE_BYP:    dout_reg <= byp_reg;
                        MODE_INTERP: dout_reg <= interp;
                        default:     dout_reg <= b_reg;
                    endcase
                end
            end
        end

        assign dataout[gi*W +: W] = dout_reg;
    end

endmodule

// File: tb/tb_psdi_rate_degrade.sv
// Scoreboard bench for psdi_rate_degrade: a sample-level reference model
// predicts each output; a negedge monitor checks value and arrival cycle.
module tb_psdi_rate_degrade;
    localparam int NCH  = 2;
    localparam int W    = 18;
    localparam int KMAX = 4;

    logic             clock, reset, data_en;
    logic [1:0]       mode;
    logic [2:0]       nfreq_log2;
    logic [4:0]       nquant;
    logic [NCH*W-1:0] datain, dataout;
    logic             endataout;

    psdi_rate_degrade #(.NCH(NCH), .W(W), .KMAX(KMAX)) dut (
        .clock     (clock),
        .reset     (reset),
        .data_en   (data_en),
        .mode      (mode),
        .nfreq_log2(nfreq_log2),
        .nquant    (nquant),
        .datain    (datain),
        .dataout   (dataout),
        .endataout (endataout)
    );

    typedef struct {
        logic [NCH*W-1:0] data;
        int               cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    bit     rst_chk = 0;

    int     m_mode, m_k, m_nq, m_phase;
    longint m_a[NCH], m_b[NCH];

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic longint floordiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint model_requant(input longint x, input int nq);
        longint step, r, mx;
        if (nq >= W) return x;
        step = longint'(1) << (W - nq);
        r    = floordiv(x + step / 2, step) * step;
        mx   = floordiv((longint'(1) << (W - 1)) - 1, step) * step;
        if (r > mx) r = mx;
        return r;
    endfunction

    function automatic void model_load_cfg();
        m_mode = int'(mode);
        m_k    = (int'(nfreq_log2) > KMAX) ? KMAX : int'(nfreq_log2);
        m_nq   = (nquant == 5'd0 || int'(nquant) > W) ? W : int'(nquant);
    endfunction

    function automatic void model_reset();
        model_load_cfg();
        m_phase = 0;
        for (int c = 0; c < NCH; c++) begin
            m_a[c] = 0;
            m_b[c] = 0;
        end
    endfunction

    function automatic void model_step(input logic [NCH*W-1:0] x, output bit emit,
                                       output logic [NCH*W-1:0] y);
        bit     cap;
        longint xs, v;
        cap = (m_phase == 0);
        y   = '0;
        for (int c = 0; c < NCH; c++) begin
            xs = longint'($signed(x[c*W +: W]));
            if (m_mode != 0 && cap) begin
                if (m_mode == 3) m_a[c] = m_b[c];
                m_b[c] = (m_mode >= 2) ? model_requant(xs, m_nq) : xs;
            end
            case (m_mode)
                0:       v = xs;
                3:       v = m_a[c] + floordiv((m_b[c] - m_a[c]) * m_phase, longint'(1) << m_k);
                default: v = m_b[c];
            endcase
            y[c*W +: W] = W'(v);
        end
        emit = (m_mode == 0) || (m_mode == 3) || cap;
        if (m_phase == (1 << m_k) - 1) begin
            m_phase = 0;
            model_load_cfg();
        end else begin
            m_phase = m_phase + 1;
        end
    endfunction

    function automatic logic [NCH*W-1:0] rnd_vec();
        logic [NCH*W-1:0] v;
        for (int c = 0; c < NCH; c++) begin
            case ($urandom_range(0, 7))
                0:       v[c*W +: W] = {1'b0, {(W-1){1'b1}}};
                1:       v[c*W +: W] = {1'b1, {(W-1){1'b0}}};
                2:       v[c*W +: W] = {W{1'b1}};
                3:       v[c*W +: W] = W'($urandom_range(0, 2000)) - W'(1000);
                default: v[c*W +: W] = W'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic set_ports(input int md, input int k, input int nq);
        mode       = 2'(md);
        nfreq_log2 = 3'(k);
        nquant     = 5'(nq);
    endtask

    // Called on a negedge; output is due three posedges later.
    task automatic issue(input logic [NCH*W-1:0] x, input int gap);
        bit               emit;
        logic [NCH*W-1:0] y;
        exp_t             e;
        model_step(x, emit, y);
        if (emit) begin
            e.data = y;
            e.cyc  = cyc + 3;
            exp_q.push_back(e);
        end
        datain  = x;
        data_en = 1'b1;
        @(negedge clock);
        data_en = 1'b0;
        repeat (gap - 1) @(negedge clock);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        repeat (n) begin
            @(negedge clock);
            rst_chk = 1'b1;
            data_en = ~data_en;
            datain  = rnd_vec() | 36'h1;
        end
        data_en = 1'b0;
        reset   = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        rst_chk = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (rst_chk) begin
            n_checks++;
            if (dataout !== '0 || endataout !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_zero: got dataout=%h endataout=%b, want 0/0 (cycle %0d)",
                         dataout, endataout, cyc);
            end
        end else begin
            if (endataout === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out: got endataout=1 dataout=%h at cycle %0d, want no output",
                             dataout, cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (dataout !== e.data) begin
                        n_fail++;
                        $display("FAIL out_data: got %h, want %h (cycle %0d)", dataout, e.data, cyc);
                    end
                    n_checks++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL out_timing: got cycle %0d, want cycle %0d", cyc, e.cyc);
                    end
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_out: got no pulse by cycle %0d, want %h at cycle %0d",
                         cyc, e.data, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end by cycle %0d, want test completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [NCH*W-1:0] v;
        reset   = 1'b0;
        data_en = 1'b0;
        datain  = '0;
        set_ports(0, 0, 0);
        do_reset(5);

        // Bypass
        set_ports(0, 0, 0);
        do_reset(3);
        v = rnd_vec();
        v[W-1:0] = 18'h12345;
        issue(v, 3);
        for (int i = 0; i < 4; i++) issue(rnd_vec(), $urandom_range(3, 5));

        // Hold + requantize: saturation and rounding
        set_ports(2, 2, 8);
        do_reset(3);
        for (int i = 0; i < 12; i++) begin
            v = rnd_vec();
            if (i == 0) v[W-1:0] = 18'h1FFFF;
            if (i == 4) v[W-1:0] = 18'h3FFFF;
            issue(v, $urandom_range(3, 4));
        end

        // Interpolation ramp 0 -> 400
        set_ports(3, 2, 18);
        do_reset(3);
        for (int i = 0; i < 20; i++) begin
            v = '0;
            if (i >= 8) begin
                v[W-1:0]   = 18'd400;
                v[2*W-1:W] = -18'sd400;
            end
            issue(v, 3);
        end

        // Config change mid-period takes effect after the wrap
        set_ports(1, 2, 0);
        do_reset(3);
        issue(rnd_vec(), 3);
        nfreq_log2 = 3'd0;
        for (int i = 0; i < 8; i++) issue(rnd_vec(), 3);

        // Reset mid-period
        set_ports(1, 3, 0);
        do_reset(3);
        for (int i = 0; i < 5; i++) issue(rnd_vec(), 3);
        do_reset(4);
        for (int i = 0; i < 3; i++) issue(rnd_vec(), 3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0)
                set_ports($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 4));
            issue(rnd_vec(), $urandom_range(3, 6));
        end

        repeat (6) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outputs outstanding, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psdi_rate_degrade.md
# psdi_rate_degrade

Parametrised multichannel successor to the fixed two-channel downsample/requantize path in the PSDI audio DSP. Per channel, it decimates by 2^k, requantizes to Nquant bits with rounding and saturation, and reconstructs the full-rate stream by zero-order hold or linear interpolation. Runtime mode selects which stages are active. It sits between the lowpass filters and the output mux of `psdi_dsp`, clocked by the 48 kHz `data_en` strobe.

## Interface
- NCH, 2, number of audio channels
- W, 18, sample width (signed two's complement)
- KMAX, 4, maximum log2 decimation factor (divide up to 16)
- clock  in  1  master clock
- reset  in  1  synchronous, active-low reset
- data_en  in  1  input sample strobe, one cycle per 48 kHz sample
- mode  in  2  00 bypass, 01 hold, 10 hold+requant, 11 interp+requant
- nfreq_log2  in  3  decimation exponent k; values above KMAX clamp to KMAX
- nquant  in  5  output bits; 0 or greater than W means W (no requantization)
- datain  in  NCH*W  channel c at bits [c*W +: W]
- dataout  out  NCH*W  processed samples, same packing
- endataout  out  1  one-cycle pulse when dataout holds a new value

## Operation
- Configuration register (cfg_mode, cfg_k, cfg_nq) is loaded from the ports during reset and at every config boundary.
  - A config boundary is a `data_en` where phase == 2^cfg_k − 1. When cfg_k = 0, every `data_en` is a boundary.
  - Port changes at any other time are ignored until the next boundary.
- Phase counter (KMAX bits) advances on `data_en`, counting modulo 2^cfg_k. The new config takes effect at the phase-0 sample that follows the boundary.
- Capture tick: a `data_en` with phase == 0.
- Requantize (used in modes 10 and 11, applied per channel before storage):
  - Add 2^(W−nq−1) as round-half-up, computed at W+1 bits.
  - On positive overflow, saturate to the max value whose low W−nq bits are zero.
  - Clear the low W−nq bits.
  - nq = W passes the sample through unchanged.
- Mode 00: dataout = datain. endataout on every `data_en`.
- Modes 01 and 10: on a capture tick, B ← the (requantized) sample, then dataout = B. endataout on capture ticks only.
- Mode 11:
  - On a capture tick, A ← B and B ← requant(sample).
  - On every `data_en`: dataout = A + (((B − A) · phase) >>> cfg_k).
  - Arithmetic: difference at W+1 bits, product at W+1+KMAX bits, arithmetic shift. The result always lies between A and B, so it fits W bits without further saturation.
  - endataout on every `data_en`.
- A and B are cleared on reset. A mode change at a boundary does not clear them.

## Timing
- All outputs are registered. dataout and endataout update at edge t+2, where t is the edge that samples `data_en`.
  - Stage 1: capture, phase, and A/B update.
  - Stage 2: interpolate/select into the output register.
- endataout is high for exactly one cycle per output sample.
- Minimum `data_en` spacing is 3 clocks. At 48 kHz the spacing is far larger.
- Mode 11 group delay: 2^k input samples plus 2 clocks.
- Reset (reset = 0 at a rising edge):
  - dataout = 0, endataout = 0, phase = 0, A = B = 0.
  - The in-flight stage-1 pulse is dropped.
  - The config register loads the current ports.
- Reset asserted mid-period discards the partial decimation period. The first `data_en` after reset release is a capture tick.
- `data_en` coinciding with the reset edge is ignored.
- Phase wraps from 2^cfg_k − 1 to 0 with no idle cycle.

## Structure
- Shared package `psdi_dsp_pkg`:
  - mode constants MODE_BYP, MODE_HOLD, MODE_HOLDQ, MODE_INTERP
  - KMAX default
  - a function that clamps nquant to 1..W
- Sub-module `psdi_requant`: combinational, one instance per channel through a generate loop over NCH. Parameter W. Ports: datain, nq, dataout.
- The phase counter, config register, and pipeline control are shared by all channels.

## Test plan
- Reset: hold reset low for 5 clocks with `data_en` toggling and datain nonzero -> dataout = 0 and endataout = 0 throughout, and for 2 clocks after release.
- Bypass: mode 00, datain ch0 = 18'h12345 -> dataout ch0 = 18'h12345 at t+2, endataout pulse on every `data_en`.
- Hold plus saturation/rounding: mode 10, k = 2, nquant = 8.
  - Input 18'h1FFFF -> 18'h1FC00 (saturate).
  - Input 18'h3FFFF -> 18'h00000 (round).
  - endataout on every 4th `data_en` only.
- Interpolation: mode 11, k = 2, nquant = 18, ch0 held at 0 then stepped to 400 -> after one capture of 400, successive outputs 0, 100, 200, 300, then 400 once 400 is held in both A and B.
- Config boundary: mode 01, k = 2; change nfreq_log2 to 0 at phase 1 -> endataout keeps the every-4th spacing until the wrap, then pulses on every `data_en`.
- Reset mid-period: mode 01, k = 3; assert reset at phase 5 -> outputs 0, and the first `data_en` after release is a capture tick with endataout 2 clocks later.
